alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//   Single-request issue stage sitting in front of an external combinational
//   ALU. A request (operands plus main-decoder ALU class, funct3, funct7 bit 5)
//   is accepted in IDLE and decoded into an ALU opcode. The opcode and operands
//   are presented to the ALU for exactly one ISSUE cycle. The ALU result is
//   then captured and offered in RESP until the consumer accepts it.
//   A saturating counter tracks completed legal operations.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake
//   req_a, req_b           operands
//   req_alu_op             00 add, 01 sub, 10 R-type, 11 reserved
//   req_funct3, req_funct7b5  R-type qualifiers
//   alu_opcode/alu_a/alu_b registered drive to the external ALU
//   alu_result             combinational ALU result for the values above
//   res_valid / res_ready  result handshake
//   res_data, res_err      captured result and illegal-encoding flag
//   op_count               saturating count of legal results delivered
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_alu_op,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  output logic [3:0]       alu_opcode,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q;
  logic [3:0]       alu_opcode_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic             illegal_q;
  logic [31:0]      res_data_q;
  logic             res_err_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic [3:0]       dec_opcode;
  logic             dec_illegal;

  // Request decode, evaluated on the live request fields; only sampled in IDLE.
  always_comb begin
    dec_opcode  = OP_ADD;
    dec_illegal = 1'b0;
    unique case (req_alu_op)
      2'b00: dec_opcode = OP_ADD;
      2'b01: dec_opcode = OP_SUB;
      2'b10: begin
        unique case (req_funct3)
          3'b000:  dec_opcode = req_funct7b5 ? OP_SUB : OP_ADD;
          3'b111:  dec_opcode = OP_AND;
          3'b110:  dec_opcode = OP_OR;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Saturating increment: stick at all-ones rather than wrap.
  always_comb begin
    count_d = count_q;
    if (count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_opcode_q <= OP_AND;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      illegal_q    <= 1'b0;
      res_data_q   <= '0;
      res_err_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            alu_opcode_q <= dec_opcode;
            alu_a_q      <= req_a;
            alu_b_q      <= req_b;
            illegal_q    <= dec_illegal;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          res_data_q <= illegal_q ? 32'h0 : alu_result;
          res_err_q  <= illegal_q;
          state_q    <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            if (!res_err_q) begin
              count_q <= count_d;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == RESP);
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign op_count   = count_q;

endmodule
